// File: rtl/seq_mult32_if.sv
// Handshake bundle between seq_mult32 and the datapath that issues multiplies.
interface seq_mult32_if #(parameter int WIDTH = 32);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input  busy, done, product);
  modport slave  (input  start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult32.sv
// Unsigned 32x32->64 shift-and-add multiplier, one RCA32 addition per clock,
// with a start/busy/done handshake toward the datapath above.

module rca32_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module rca32 #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      rca32_fa u_fa (.x(a[i]), .y(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
  endgenerate
  assign cout = c[WIDTH];
endmodule

module seq_mult32 #(parameter int WIDTH = 32) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult32_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [2*WIDTH-1:0] p_next;

  assign add_b  = p_q[0] ? m_q : '0;
  // Carry-out is kept as the new MSB so the 33-bit partial sum never overflows.
  assign p_next = {cout, sum, p_q[WIDTH-1:1]};

  rca32 #(.WIDTH(WIDTH)) u_add (
    .a   (p_q[2*WIDTH-1:WIDTH]),
    .b   (add_b),
    .cin (1'b0),
    .s   (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == 6'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          m_q   <= bus.a;
          p_q   <= {{WIDTH{1'b0}}, bus.b};
          cnt_q <= '0;
        end
        RUN: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) product_q <= p_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult32.sv
// Vector table plus hand-built corner sequences; a done-driven scoreboard checks products.
module tb_seq_mult32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  logic prev_done = 1'b0;

  seq_mult32_if mif ();
  seq_mult32 dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mif.done) begin
      if (prev_done) chk("done_pulse_width", 64'd2, 64'd1);
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("product", mif.product, exp_q.pop_front());
    end
    prev_done = mif.done;
  end

  task automatic wait_done(output int cyc, output int low);
    bit ok = 0;
    cyc = 0;
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (!mif.busy) low++;
      if (mif.done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] texp);
    int cyc, low;
    @(negedge clk);
    mif.start = 1'b1; mif.a = ta; mif.b = tb;
    exp_q.push_back(texp);
    @(negedge clk);
    mif.start = 1'b0; mif.a = $urandom; mif.b = $urandom;
    wait_done(cyc, low);
    chk("latency", 64'(cyc), 64'd32);
    chk("busy_low_cycles", 64'(low), 64'd1);
    @(negedge clk);
    chk("done_cleared", {63'd0, mif.done}, 64'd0);
    chk("product_held", mif.product, texp);
  endtask

  initial begin
    int cyc, low;
    mif.start = 1'b0; mif.a = '0; mif.b = '0;
    vecs[0] = '{32'd10, 32'd20, 64'd200};
    vecs[1] = '{32'hffffffff, 32'hffffffff, 64'hfffffffe00000001};
    vecs[2] = '{32'he3244bbe, 32'd1, 64'h00000000e3244bbe};
    vecs[3] = '{32'd0, 32'h0d332ff2, 64'd0};
    vecs[4] = '{32'h80000000, 32'd2, 64'h0000000100000000};
    vecs[5] = '{32'h12345678, 32'h9abcdef0, 64'h0b00ea4e242d2080};

    #3;
    chk("reset_busy", {63'd0, mif.busy}, 64'd0);
    chk("reset_done", {63'd0, mif.done}, 64'd0);
    chk("reset_product", mif.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

    // start pulse during RUN must be ignored
    @(negedge clk);
    mif.start = 1'b1; mif.a = 32'd3; mif.b = 32'd5;
    exp_q.push_back(64'd15);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    mif.start = 1'b1; mif.a = 32'd7; mif.b = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done(cyc, low);
    chk("ignored_start_latency", 64'(cyc), 64'd22);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", {63'd0, mif.busy}, 64'd0);
    run_op(32'd7, 32'd7, 64'd49);

    // asynchronous reset mid-RUN aborts without a done pulse
    @(negedge clk);
    mif.start = 1'b1; mif.a = 32'h10000; mif.b = 32'h10000;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, mif.busy}, 64'd0);
    chk("abort_done", {63'd0, mif.done}, 64'd0);
    chk("abort_product", mif.product, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_restart", {63'd0, mif.busy}, 64'd0);
    run_op(32'h10000, 32'h10000, 64'h0000000100000000);

    // start held high: back-to-back every 34 cycles
    @(negedge clk);
    mif.start = 1'b1; mif.a = 32'd2; mif.b = 32'd3;
    repeat (3) exp_q.push_back(64'd6);
    wait_done(cyc, low);
    chk("b2b_first_latency", 64'(cyc), 64'd33);
    chk("b2b_first_low", 64'(low), 64'd1);
    for (int k = 0; k < 2; k++) begin
      wait_done(cyc, low);
      chk("b2b_period", 64'(cyc), 64'd34);
      chk("b2b_busy_low", 64'(low), 64'd2);
    end
    mif.start = 1'b0;
    @(negedge clk);
    chk("b2b_product_held", mif.product, 64'd6);
    @(negedge clk);
    chk("b2b_stopped", {63'd0, mif.busy}, 64'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
